// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_pkg
//  Purpose  : Shared constants for the binary-to-BCD converter: default
//             widths, FSM state encoding and the decimal saturation limit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

    // Default widths: 27 bits holds 99_999_999, eight display digits.
    localparam int c_bin_w  = 27;
    localparam int c_digits = 8;

    // FSM state encoding.
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // Saturation limit at the default digit count.
    localparam logic [63:0] c_sat_max = pow10_minus1(c_digits);

endpackage : bin_to_bcd_pkg
`default_nettype wire

// File: rtl/bin_to_bcd_adj3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_adj3
//  Purpose  : Double-dabble digit correction: adds 3 to a BCD digit that is
//             5 or more so the following left shift carries into the next
//             decimal position.
//  Ports    : i_digit [3:0] - scratch digit before correction
//             o_digit [3:0] - corrected digit
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_adj3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_adj3
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd
//  Purpose  : Sequential double-dabble binary-to-packed-BCD converter, one
//             bit per clock, with saturation to all 9s on overflow.
//  Ports    : sys_clk    - clock, rising edge
//             sys_rst_n  - asynchronous active-low reset
//             start      - conversion request (accepted only in IDLE)
//             bin_in     - unsigned binary value, captured on accept
//             busy       - high from accept until the result is registered
//             done       - one-cycle pulse, bcd_out/ovf updated
//             bcd_out    - packed BCD result, digit 0 in bits [3:0]
//             ovf        - last accepted value exceeded 10^DIGITS-1
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = c_bin_w,
    parameter int DIGITS = c_digits
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int                c_sw       = 4 * DIGITS;
    localparam int                c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [63:0]       c_sat_lim  = pow10_minus1(DIGITS);
    localparam logic [c_sw-1:0]   c_all9     = {DIGITS{4'h9}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [BIN_W-1:0]    r_bin;
    logic [c_sw-1:0]     r_scratch;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_ovf_pend;

    logic                w_load;
    logic                w_iter;
    logic                w_finish;
    logic [c_sw-1:0]     w_adj;
    logic [c_sw-1:0]     w_scratch_next;

    // ------------------------------------------------------------------
    // Per-digit add-3 correction applied before every shift.
    // ------------------------------------------------------------------
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_adj3 u_adj (
            .i_digit (r_scratch[4*d +: 4]),
            .o_digit (w_adj[4*d +: 4])
        );
    end

    // Shift {scratch, binary} left; binary MSB enters scratch bit 0 and any
    // carry out of the top digit falls off (only possible when saturating).
    assign w_scratch_next = (w_adj << 1) | c_sw'(r_bin[BIN_W-1]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_shift;
                end
            end
            c_st_shift: begin
                // Counter holds the index of the iteration being run now.
                if (r_cnt == c_cnt_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (datapath enables)
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            c_st_idle:  w_load   = start;
            c_st_shift: w_iter   = 1'b1;
            c_st_done:  w_finish = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bin      <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (w_load) begin
                r_bin      <= bin_in;
                r_scratch  <= '0;
                r_cnt      <= '0;
                // Overflow is decided from the captured value, not the
                // scratch result, which may have lost its top carry.
                r_ovf_pend <= (64'(bin_in) > c_sat_lim);
                busy       <= 1'b1;
            end

            if (w_iter) begin
                r_scratch <= w_scratch_next;
                r_bin     <= r_bin << 1;
                r_cnt     <= r_cnt + c_cnt_one;
            end

            // Results are published only here, so partial scratch values
            // never reach bcd_out.
            if (w_finish) begin
                bcd_out <= r_ovf_pend ? c_all9 : r_scratch;
                ovf     <= r_ovf_pend;
                done    <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

endmodule : bin_to_bcd
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd
//  Purpose  : Directed self-checking bench for bin_to_bcd at default widths.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        ovf;

    int n_chk;
    int n_fail;

    bin_to_bcd #(
        .BIN_W  (27),
        .DIGITS (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    // 50 MHz clock.
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion at the next edge, wait (bounded) for done and check
    // latency (done after edge k+28), result and overflow flag.
    task automatic run_conv(input string tag, input logic [26:0] val,
                            input logic [31:0] exp_bcd, input logic exp_ovf);
        int cyc;
        bin_in = val;
        start  = 1'b1;
        tick();
        chk({tag, "_busy_on_accept"}, 64'(busy), 64'd1);
        start  = 1'b0;
        bin_in = 27'h5A5A5A5;
        cyc    = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd28);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dones;
        int cyc;
        n_chk     = 0;
        n_fail    = 0;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        bin_in    = '0;

        // Reset state, before any clock edge.
        #5;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd",  64'(bcd_out), 64'd0);
        chk("rst_ovf",  64'(ovf), 64'd0);
        tick();
        tick();
        sys_rst_n = 1'b1;

        // Zero: detailed busy/done timing across the whole conversion.
        bin_in = 27'd0;
        start  = 1'b1;
        tick();                              // edge k
        start  = 1'b0;
        chk("zero_busy_k", 64'(busy), 64'd1);
        for (int e = 1; e <= 27; e++) begin  // edges k+1 .. k+27
            tick();
            chk($sformatf("zero_busy_k%0d", e), 64'(busy), 64'd1);
            chk($sformatf("zero_nodone_k%0d", e), 64'(done), 64'd0);
        end
        tick();                              // edge k+28
        chk("zero_done",   64'(done), 64'd1);
        chk("zero_busy_off", 64'(busy), 64'd0);
        chk("zero_bcd",    64'(bcd_out), 64'd0);
        chk("zero_ovf",    64'(ovf), 64'd0);
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);

        run_conv("mixed", 27'd12_345_678, 32'h12345678, 1'b0);
        tick();
        chk("mixed_hold_bcd", 64'(bcd_out), 64'h12345678);
        run_conv("max",   27'd99_999_999, 32'h99999999, 1'b0);
        run_conv("ovf",   27'd100_000_000, 32'h99999999, 1'b1);
        run_conv("small", 27'd9, 32'h00000009, 1'b0);

        // Start while busy: second request at k+10 must be ignored.
        bin_in = 27'd42;
        start  = 1'b1;
        tick();                              // edge k
        start  = 1'b0;
        dones  = 0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 10) begin
                bin_in = 27'd5;
                start  = 1'b1;
            end
            tick();
            if (e == 10) begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                chk("busy_start_latency", 64'(e), 64'd28);
                chk("busy_start_bcd", 64'(bcd_out), 64'h00000042);
                // Request in the cycle right after done (state is IDLE).
                bin_in = 27'd5;
                start  = 1'b1;
                tick();
                start  = 1'b0;
                chk("b2b_busy", 64'(busy), 64'd1);
                cyc = 0;
                while (!done && cyc < 40) begin
                    tick();
                    cyc++;
                end
                chk("b2b_latency", 64'(cyc), 64'd28);
                chk("b2b_bcd", 64'(bcd_out), 64'h00000005);
                break;
            end
        end
        chk("busy_start_one_done", 64'(dones), 64'd1);
        tick();

        // Mid-op reset at edge k+15.
        run_conv("pre_rst", 27'd31_415_926, 32'h31415926, 1'b0);
        bin_in = 27'd88_888_888;
        start  = 1'b1;
        tick();                              // edge k
        start  = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_bcd",  64'(bcd_out), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        #5;
        sys_rst_n = 1'b1;
        dones = 0;
        for (int e = 0; e < 35; e++) begin
            tick();
            if (done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        chk("midrst_bcd_hold", 64'(bcd_out), 64'd0);
        run_conv("after_rst", 27'd7, 32'h00000007, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_bin_to_bcd
`default_nettype wire
